// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: (a*b) mod q using MSB-first double-and-add,
// one bit of b per cycle. Single job in flight with valid/ready on both sides.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module mod_mul_seq #(
  parameter int DW = `DATA_SIZE_ARB,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [TW-1:0] tag_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out,
  output logic [TW-1:0] tag_out,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] a_q, b_q, acc_q;
  logic [TW-1:0] tag_q;
  logic [CW-1:0] cnt_q;

  logic [DW:0]   q_ext, t_dbl, t_red, u_sum;
  logic [DW-1:0] u_red, acc_nx;

  // Double-and-add step; both sums fit in DW+1 bits while acc, a < q.
  always_comb begin
    q_ext  = {1'b0, q};
    t_dbl  = {acc_q, 1'b0};
    t_red  = (t_dbl >= q_ext) ? (t_dbl - q_ext) : t_dbl;
    u_sum  = t_red + {1'b0, a_q};
    u_red  = (u_sum >= q_ext) ? DW'(u_sum - q_ext) : u_sum[DW-1:0];
    acc_nx = b_q[cnt_q] ? u_red : t_red[DW-1:0];
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (cnt_q == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            tag_q <= tag_in;
            acc_q <= '0;
            cnt_q <= CW'(DW - 1);
          end
        end
        CALC: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out     = acc_q;
  assign tag_out = tag_q;

endmodule
